// File: rtl/keypad_scan_controller_if.sv
// Keypad pin and paddle-strobe bundle shared by the scan controller and its consumer.
// The controller takes the master side: it drives the rows and all decoded outputs.
interface keypad_scan_controller_if;
    logic        wire1;
    logic        wire2;
    logic        wire3;
    logic        wire4;
    logic        wire5;
    logic        wire6;
    logic        wire7;
    logic        wire8;
    logic [14:0] keys;
    logic        keys_valid;
    logic        p1_up;
    logic        p1_down;
    logic        p2_up;
    logic        p2_down;

    modport master (
        input  wire1, wire2, wire3,
        output wire4, wire5, wire6, wire7, wire8,
        output keys, keys_valid,
        output p1_up, p1_down, p2_up, p2_down
    );

    modport slave (
        output wire1, wire2, wire3,
        input  wire4, wire5, wire6, wire7, wire8,
        input  keys, keys_valid,
        input  p1_up, p1_down, p2_up, p2_down
    );
endinterface

// File: rtl/keypad_scan_controller.sv
// Scans the shared 5x3 Pong keypad, debounces whole frames and turns the
// debounced direction keys of both players into rate-limited movement strobes.
module keypad_scan_controller #(
    parameter int unsigned SETTLE_CYCLES   = 1000,
    parameter int unsigned DEBOUNCE_FRAMES = 3,
    parameter logic [23:0] REPEAT_CYCLES   = 24'd2_000_000
) (
    input logic                      clk,
    input logic                      reset,
    keypad_scan_controller_if.master pins_io
);

    localparam int SW = $clog2(SETTLE_CYCLES);
    localparam int DW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 2);
    localparam logic [DW-1:0] DEB_FULL    = DW'(DEBOUNCE_FRAMES);

    localparam logic [1:0] ST_DRIVE   = 2'd0;
    localparam logic [1:0] ST_SAMPLE  = 2'd1;
    localparam logic [1:0] ST_ADVANCE = 2'd2;

    localparam logic [0:0] MV_IDLE = 1'b0;
    localparam logic [0:0] MV_HOLD = 1'b1;

    localparam logic [1:0] DIR_IDLE = 2'd0;
    localparam logic [1:0] DIR_UP   = 2'd1;
    localparam logic [1:0] DIR_DOWN = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [2:0]    row_q, row_d;
    logic [SW-1:0] settle_q, settle_d;
    logic          run_q;
    logic [11:0]   raw_q, raw_d;
    logic [14:0]   prev_q, prev_d;
    logic [DW-1:0] stable_q, stable_d;
    logic [14:0]   keys_q, keys_d;
    logic          keys_valid_q, keys_valid_d;
    logic [4:0]    rows_q, rows_d;

    logic [2:0]    cols_w;
    logic [14:0]   frame_w;
    logic [DW-1:0] stable_nx_w;
    logic [1:0]    up_w;
    logic [1:0]    dn_w;

    assign cols_w  = ~{pins_io.wire3, pins_io.wire2, pins_io.wire1};
    // Row 4 lands straight into the frame; rows 0-3 come from the partial raw frame.
    assign frame_w = {cols_w, raw_q};
    assign stable_nx_w = (frame_w != prev_q) ? DW'(1)
                       : ((stable_q == DEB_FULL) ? stable_q : stable_q + DW'(1));

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        settle_d     = settle_q;
        raw_d        = raw_q;
        prev_d       = prev_q;
        stable_d     = stable_q;
        keys_d       = keys_q;
        keys_valid_d = 1'b0;
        if (run_q) begin
            case (state_q)
                ST_DRIVE: begin
                    if (settle_q == SETTLE_LAST) begin
                        settle_d = '0;
                        state_d  = ST_SAMPLE;
                    end else begin
                        settle_d = settle_q + SW'(1);
                    end
                end
                ST_SAMPLE: begin
                    state_d = ST_ADVANCE;
                    for (int r = 0; r < 4; r++) begin
                        if (row_q == 3'(r)) raw_d[r*3 +: 3] = cols_w;
                    end
                    if (row_q == 3'd4) begin
                        prev_d   = frame_w;
                        stable_d = stable_nx_w;
                        if ((stable_nx_w == DEB_FULL) && (frame_w != keys_q)) begin
                            keys_d       = frame_w;
                            keys_valid_d = 1'b1;
                        end
                    end
                end
                ST_ADVANCE: begin
                    row_d   = (row_q == 3'd4) ? 3'd0 : row_q + 3'd1;
                    state_d = ST_DRIVE;
                end
                default: state_d = ST_DRIVE;
            endcase
        end
        // Registered row drives follow the next state so pins and FSM stay aligned.
        rows_d = (state_d == ST_ADVANCE) ? 5'h1F : ~(5'b00001 << row_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_DRIVE;
            row_q        <= 3'd0;
            settle_q     <= '0;
            run_q        <= 1'b0;
            raw_q        <= '0;
            prev_q       <= '0;
            stable_q     <= '0;
            keys_q       <= '0;
            keys_valid_q <= 1'b0;
            rows_q       <= 5'h1F;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            settle_q     <= settle_d;
            run_q        <= 1'b1;
            raw_q        <= raw_d;
            prev_q       <= prev_d;
            stable_q     <= stable_d;
            keys_q       <= keys_d;
            keys_valid_q <= keys_valid_d;
            rows_q       <= rows_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_player
            localparam int UP_BIT = 2 * gi;
            localparam int DN_BIT = 3 + 2 * gi;

            logic [1:0]  dir_w;
            logic [0:0]  mv_q, mv_d;
            logic [23:0] cnt_q, cnt_d;
            logic        up_q, up_d;
            logic        dn_q, dn_d;

            always_comb begin
                dir_w = DIR_IDLE;
                if (keys_q[UP_BIT] && !keys_q[DN_BIT]) dir_w = DIR_UP;
                if (keys_q[DN_BIT] && !keys_q[UP_BIT]) dir_w = DIR_DOWN;
            end

            // The dead zone only releases on expiry; a new direction waits for it.
            always_comb begin
                mv_d  = mv_q;
                cnt_d = cnt_q;
                up_d  = 1'b0;
                dn_d  = 1'b0;
                case (mv_q)
                    MV_IDLE: begin
                        if (dir_w != DIR_IDLE) begin
                            up_d  = (dir_w == DIR_UP);
                            dn_d  = (dir_w == DIR_DOWN);
                            cnt_d = 24'd1;
                            mv_d  = MV_HOLD;
                        end
                    end
                    default: begin
                        if (cnt_q >= REPEAT_CYCLES) begin
                            if (dir_w != DIR_IDLE) begin
                                up_d  = (dir_w == DIR_UP);
                                dn_d  = (dir_w == DIR_DOWN);
                                cnt_d = 24'd1;
                            end else begin
                                cnt_d = 24'd0;
                                mv_d  = MV_IDLE;
                            end
                        end else begin
                            cnt_d = cnt_q + 24'd1;
                        end
                    end
                endcase
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    mv_q  <= MV_IDLE;
                    cnt_q <= 24'd0;
                    up_q  <= 1'b0;
                    dn_q  <= 1'b0;
                end else begin
                    mv_q  <= mv_d;
                    cnt_q <= cnt_d;
                    up_q  <= up_d;
                    dn_q  <= dn_d;
                end
            end

            assign up_w[gi] = up_q;
            assign dn_w[gi] = dn_q;
        end
    endgenerate

    assign pins_io.wire4      = rows_q[0];
    assign pins_io.wire5      = rows_q[1];
    assign pins_io.wire6      = rows_q[2];
    assign pins_io.wire7      = rows_q[3];
    assign pins_io.wire8      = rows_q[4];
    assign pins_io.keys       = keys_q;
    assign pins_io.keys_valid = keys_valid_q;
    assign pins_io.p1_up      = up_w[0];
    assign pins_io.p1_down    = dn_w[0];
    assign pins_io.p2_up      = up_w[1];
    assign pins_io.p2_down    = dn_w[1];

endmodule

// File: tb/tb_keypad_scan_controller.sv
// Scoreboard bench for keypad_scan_controller with SETTLE=4, DEBOUNCE=2, REPEAT=50.
// Stimulus queues expected keys/strobe events; a monitor pops them as the DUT emits.
module tb_keypad_scan_controller;

    typedef struct {
        bit          is_key;
        logic [14:0] val;
        int          gap;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [14:0] pressed = '0;
    int          total = 0;
    int          bad = 0;
    int          n_events = 0;
    int          cyc = 0;
    int          last_cyc = 0;
    int          k = -2;
    exp_t        sb_q[$];

    keypad_scan_controller_if kp();

    keypad_scan_controller #(
        .SETTLE_CYCLES(4),
        .DEBOUNCE_FRAMES(2),
        .REPEAT_CYCLES(24'd50)
    ) dut (
        .clk(clk),
        .reset(rst),
        .pins_io(kp)
    );

    always #5 clk = ~clk;

    // Passive keypad: a pressed key pulls its column low while its row is driven low.
    logic [4:0] rl;
    logic [3:0] strb;
    assign rl = ~{kp.wire8, kp.wire7, kp.wire6, kp.wire5, kp.wire4};
    assign kp.wire1 = ~|(rl & {pressed[12], pressed[9], pressed[6], pressed[3], pressed[0]});
    assign kp.wire2 = ~|(rl & {pressed[13], pressed[10], pressed[7], pressed[4], pressed[1]});
    assign kp.wire3 = ~|(rl & {pressed[14], pressed[11], pressed[8], pressed[5], pressed[2]});
    assign strb = {kp.p2_down, kp.p2_up, kp.p1_down, kp.p1_up};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input bit is_key, input logic [14:0] val, input int gap);
        exp_t e;
        e.is_key = is_key;
        e.val    = val;
        e.gap    = gap;
        sb_q.push_back(e);
    endtask

    task automatic handle(input bit is_key, input logic [14:0] v);
        exp_t e;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_%s act=%0h exp=none t=%0t", is_key ? "keys" : "strobe", v, $time);
        end else begin
            e = sb_q.pop_front();
            chk("evt_kind", {31'b0, is_key}, {31'b0, e.is_key});
            chk(is_key ? "keys_val" : "strobe_val", {17'b0, v}, {17'b0, e.val});
            if (e.gap >= 0) chk("evt_gap", 32'(cyc - last_cyc), 32'(e.gap));
            $display("event %s val=%0h cycle=%0d gap=%0d", is_key ? "keys" : "strobe", v, cyc, cyc - last_cyc);
        end
        last_cyc = cyc;
        n_events++;
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) k <= -1;
        else if (k >= -1) k <= k + 1;
    end

    // Row sequencing reference: k counts cycles since the scan restarted.
    always @(negedge clk) begin
        int          pos;
        int          r;
        logic [4:0]  er;
        if (k >= -1) begin
            er = 5'h1F;
            if (k >= 0) begin
                pos = k % 5;
                r   = (k / 5) % 5;
                if (pos < 4) er = ~(5'b00001 << r);
            end
            chk("rows", {27'b0, kp.wire8, kp.wire7, kp.wire6, kp.wire5, kp.wire4}, {27'b0, er});
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (kp.keys_valid) handle(1'b1, kp.keys);
            if (strb != 4'b0) handle(1'b0, {11'b0, strb});
        end
    end

    task automatic wait_events(input int target, input int budget, input string name);
        int i = 0;
        while (n_events < target && i < budget) begin
            @(negedge clk);
            i++;
        end
        total++;
        if (n_events < target) begin
            bad++;
            $display("FAIL timeout_%s act=%0d exp=%0d", name, n_events, target);
        end
    endtask

    task automatic drain(input int budget, input string name);
        int i = 0;
        while (sb_q.size() != 0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL missing_%s act=%0d exp=0 pending", name, sb_q.size());
        end
        repeat (60) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rows"}, {27'b0, kp.wire8, kp.wire7, kp.wire6, kp.wire5, kp.wire4}, 32'h1F);
        chk({tag, "_keys"}, {17'b0, kp.keys}, 32'h0);
        chk({tag, "_kv"}, {31'b0, kp.keys_valid}, 32'h0);
        chk({tag, "_strobes"}, {28'b0, strb}, 32'h0);
    endtask

    initial begin
        int base;
        int i;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("first_row", {31'b0, kp.wire4}, 32'h0);

        // Idle scan: no events may appear.
        repeat (80) @(negedge clk);
        chk("idle_keys", {17'b0, kp.keys}, 32'h0);

        // P1 up held: debounced, strobe, two repeats; release right after third strobe.
        base = n_events;
        push(1'b1, 15'h0001, -1);
        push(1'b0, 15'h0001, 1);
        push(1'b0, 15'h0001, 50);
        push(1'b0, 15'h0001, 50);
        pressed = 15'h0001;
        wait_events(base + 4, 400, "p1_up_hold");
        push(1'b1, 15'h0000, 49);
        pressed = 15'h0000;
        drain(200, "p1_up_release");

        // One-frame glitch on bit 5 must be filtered.
        i = 0;
        while (kp.wire5 !== 1'b0 && i < 50) begin
            @(negedge clk);
            i++;
        end
        chk("glitch_row1_seen", {31'b0, kp.wire5}, 32'h0);
        pressed = 15'h0020;
        i = 0;
        while (kp.wire5 !== 1'b1 && i < 50) begin
            @(negedge clk);
            i++;
        end
        pressed = 15'h0000;
        repeat (100) @(negedge clk);
        chk("glitch_keys", {17'b0, kp.keys}, 32'h0);

        // Up and down together cancel; releasing up yields an immediate down strobe.
        push(1'b1, 15'h0009, -1);
        pressed = 15'h0009;
        drain(200, "p1_both");
        base = n_events;
        push(1'b1, 15'h0008, -1);
        push(1'b0, 15'h0002, 1);
        pressed = 15'h0008;
        wait_events(base + 2, 200, "p1_down");
        push(1'b1, 15'h0000, 49);
        pressed = 15'h0000;
        drain(200, "p1_down_release");

        // Direction change inside the dead zone is taken only at expiry.
        base = n_events;
        push(1'b1, 15'h0001, -1);
        push(1'b0, 15'h0001, 1);
        pressed = 15'h0001;
        wait_events(base + 2, 200, "p1_up_again");
        push(1'b1, 15'h0008, 49);
        push(1'b0, 15'h0002, 1);
        pressed = 15'h0008;
        wait_events(base + 4, 200, "p1_switch");
        push(1'b1, 15'h0000, 49);
        pressed = 15'h0000;
        drain(200, "p1_switch_release");

        // P1 up and P2 down held together strobe on the same cycles.
        base = n_events;
        push(1'b1, 15'h0021, -1);
        push(1'b0, 15'h0009, 1);
        push(1'b0, 15'h0009, 50);
        pressed = 15'h0021;
        wait_events(base + 3, 300, "dual_hold");
        push(1'b1, 15'h0000, 49);
        pressed = 15'h0000;
        drain(200, "dual_release");

        // Reset while in HOLD with the key still down.
        base = n_events;
        push(1'b1, 15'h0001, -1);
        push(1'b0, 15'h0001, 1);
        pressed = 15'h0001;
        wait_events(base + 2, 200, "pre_reset_hold");
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("hold_reset");
        base = n_events;
        push(1'b1, 15'h0001, -1);
        push(1'b0, 15'h0001, 1);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_strobes", {28'b0, strb}, 32'h0);
        chk("post_reset_row0", {31'b0, kp.wire4}, 32'h0);
        wait_events(base + 2, 200, "post_reset_hold");
        push(1'b1, 15'h0000, 49);
        pressed = 15'h0000;
        drain(200, "post_reset_release");

        // Reset in the middle of a row.
        repeat (37) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrow_reset");
        rst = 1'b0;
        @(negedge clk);
        chk("midrow_row0", {31'b0, kp.wire4}, 32'h0);
        repeat (60) @(negedge clk);

        chk("queue_empty", 32'(sb_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
